// File: rtl/bus_arbiter.sv
// Purpose     : round-robin arbiter for the shared serial bus with grant-timeout supervision.
// Latency     : one clk from a sampled request to b_grant; b_grant drops one clk after release.
// Backpressure: no new grant while b_util or slave_busy is high; losing requests stay pending.
//
// Ports:
//   clk, rstn      - clock (posedge) and asynchronous active-low reset
//   b_request      - per-master level request, held for the whole tenure
//   b_grant        - one-hot grant, all-zero when the bus has no owner
//   b_util         - shared line, high while the owner drives the bus
//   slave_busy     - shared line, blocks new grants while high
//   arb_busy       - high from grant issue until the bus is idle again
//   cur_master     - index of the current or most recent owner
//   timeout_pulse  - one-cycle pulse when a grant is reclaimed by timeout
//
// Optional feature macro: ARB_TENURE_LIMIT_EN
//   Limits a BUSY tenure to 2**TENURE_LEN cycles when another master is waiting.
//   Undefined by default, in which case tenure is unlimited and no counter exists.

module bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT_LEN = 6,
    parameter int ID_W        = 2,
    parameter int TENURE_LEN  = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] b_request,
    output logic [NUM_MASTERS-1:0] b_grant,
    input  logic                   b_util,
    input  logic                   slave_busy,
    output logic                   arb_busy,
    output logic [ID_W-1:0]        cur_master,
    output logic                   timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [TIMEOUT_LEN-1:0] CNT_MAX = '1;

    state_t                   state, state_nxt;
    logic [ID_W-1:0]          ptr, ptr_nxt;
    logic [TIMEOUT_LEN-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]          cur_nxt;
    logic [NUM_MASTERS-1:0]   grant_nxt;
    logic                     busy_nxt;
    logic                     tp_nxt;

    logic                     win_vld;
    logic [ID_W-1:0]          win_id;
    logic [ID_W-1:0]          ptr_after;
    logic                     own_req;

`ifdef ARB_TENURE_LIMIT_EN
    localparam logic [TENURE_LEN-1:0] TEN_MAX = '1;
    logic [TENURE_LEN-1:0]    tcnt, tcnt_nxt;
    logic                     others_req;
    // During BUSY the grant is one-hot on the owner, so masking by it leaves the waiters.
    assign others_req = |(b_request & ~b_grant);
`else
    // Keeps the parameter referenced when the tenure limit is compiled out.
    logic unused_tenure_len;
    assign unused_tenure_len = (TENURE_LEN > 0);
`endif

    assign own_req   = b_request[cur_master];
    assign ptr_after = (cur_master == ID_W'(NUM_MASTERS - 1)) ? '0 : cur_master + 1'b1;

    // Round-robin scan starting at ptr; first set request wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!win_vld && b_request[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        cur_nxt   = cur_master;
        grant_nxt = b_grant;
        busy_nxt  = arb_busy;
        tp_nxt    = 1'b0;
`ifdef ARB_TENURE_LIMIT_EN
        tcnt_nxt  = tcnt;
`endif
        case (state)
            IDLE: begin
                if (win_vld && !b_util && !slave_busy) begin
                    grant_nxt = NUM_MASTERS'(1) << win_id;
                    cur_nxt   = win_id;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GRANTED;
                end
            end
            GRANTED: begin
                if (b_util) begin
                    state_nxt = BUSY;
`ifdef ARB_TENURE_LIMIT_EN
                    tcnt_nxt  = '0;
`endif
                end else if (!own_req) begin
                    // Master gave up before starting: bus was never used, go straight to idle.
                    grant_nxt = '0;
                    ptr_nxt   = ptr_after;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    // Terminal count reclaims the grant instead of wrapping, so a grant
                    // lasts at most 2**TIMEOUT_LEN cycles without b_util.
                    grant_nxt = '0;
                    tp_nxt    = 1'b1;
                    ptr_nxt   = ptr_after;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BUSY: begin
                if (!own_req) begin
                    grant_nxt = '0;
                    ptr_nxt   = ptr_after;
                    state_nxt = RELEASE;
                end
`ifdef ARB_TENURE_LIMIT_EN
                else if (tcnt == TEN_MAX) begin
                    // Saturated: only pre-empt when someone else is actually waiting.
                    if (others_req) begin
                        grant_nxt = '0;
                        ptr_nxt   = ptr_after;
                        state_nxt = RELEASE;
                    end
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
`endif
            end
            RELEASE: begin
                // Owner may still be finishing a transfer; wait for the line to go quiet.
                if (!b_util) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            cur_master    <= '0;
            b_grant       <= '0;
            arb_busy      <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            cnt           <= cnt_nxt;
            cur_master    <= cur_nxt;
            b_grant       <= grant_nxt;
            arb_busy      <= busy_nxt;
            timeout_pulse <= tp_nxt;
        end
    end

`ifdef ARB_TENURE_LIMIT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose     : directed self-checking bench for bus_arbiter (3 masters, 6-bit timeout).
// Latency     : inputs driven and outputs sampled on the falling edge of clk.
// Backpressure: bench plays the masters and the shared b_util/slave_busy lines.

module tb_bus_arbiter;

    localparam int NM = 3;
`ifdef ARB_TENURE_LIMIT_EN
    localparam int TL = 4;
`else
    localparam int TL = 10;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [NM-1:0] b_request;
    logic [NM-1:0] b_grant;
    logic          b_util;
    logic          slave_busy;
    logic          arb_busy;
    logic [1:0]    cur_master;
    logic          timeout_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .TIMEOUT_LEN (6),
        .ID_W        (2),
        .TENURE_LEN  (TL)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .b_request     (b_request),
        .b_grant       (b_grant),
        .b_util        (b_util),
        .slave_busy    (slave_busy),
        .arb_busy      (arb_busy),
        .cur_master    (cur_master),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        b_request  = '0;
        b_util     = 1'b0;
        slave_busy = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [4] = '{0, 1, 2, 0};
        int zeros;

        // ---------------- reset state ----------------
        rstn       = 1'b0;
        b_request  = '0;
        b_util     = 1'b0;
        slave_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",  b_grant, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_cur",  cur_master, 0);
        chk("rst_tp",   timeout_pulse, 0);
        rstn = 1'b1;
        @(negedge clk);

        // ---------------- single request ----------------
        b_request = 3'b010;
        @(negedge clk);
        chk("single_gnt",  b_grant, 3'b010);
        chk("single_cur",  cur_master, 1);
        chk("single_busy", arb_busy, 1);
        b_util = 1'b1;
        repeat (10) @(negedge clk);
        chk("single_hold", b_grant, 3'b010);
        b_request = 3'b000;
        @(negedge clk);
        chk("single_drop", b_grant, 0);
        chk("single_busy_rel", arb_busy, 1);
        b_util = 1'b0;
        @(negedge clk);
        chk("single_idle", arb_busy, 0);

        // ---------------- round-robin ----------------
        do_reset();
        b_request = 3'b111;
        for (int k = 0; k < 4; k++) begin
            zeros = 0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (b_grant != 0) break;
                zeros++;
            end
            chk("rr_gnt", b_grant, 32'(1 << exp_order[k]));
            chk("rr_cur", cur_master, exp_order[k]);
            if (k > 0) chk("rr_idle_gap", (zeros >= 1), 1);
            b_util = 1'b1;
            repeat (5) @(negedge clk);
            b_request[exp_order[k]] = 1'b0;
            @(negedge clk);
            chk("rr_rel", b_grant, 0);
            b_util = 1'b0;
            b_request[exp_order[k]] = 1'b1;
        end

        // ---------------- timeout ----------------
        do_reset();
        b_request = 3'b100;
        @(negedge clk);
        chk("to_gnt", b_grant, 3'b100);
        repeat (63) @(negedge clk);
        chk("to_still", b_grant, 3'b100);
        chk("to_no_tp", timeout_pulse, 0);
        @(negedge clk);
        chk("to_drop", b_grant, 0);
        chk("to_tp", timeout_pulse, 1);
        b_request = 3'b101;
        @(negedge clk);
        chk("to_tp_1cyc", timeout_pulse, 0);
        chk("to_rel_gnt", b_grant, 0);
        chk("to_idle", arb_busy, 0);
        @(negedge clk);
        chk("to_next_m0", b_grant, 3'b001);

        // ---------------- blocking ----------------
        do_reset();
        slave_busy = 1'b1;
        b_request  = 3'b001;
        repeat (3) @(negedge clk);
        chk("blk_sb", b_grant, 0);
        slave_busy = 1'b0;
        @(negedge clk);
        chk("blk_sb_gnt", b_grant, 3'b001);
        b_request = 3'b000;
        @(negedge clk);
        chk("blk_abort", arb_busy, 0);
        b_util    = 1'b1;
        b_request = 3'b001;
        repeat (3) @(negedge clk);
        chk("blk_util", b_grant, 0);
        b_util = 1'b0;
        @(negedge clk);
        chk("blk_util_gnt", b_grant, 3'b001);

        // ---------------- reset mid-tenure ----------------
        do_reset();
        b_request = 3'b001;
        @(negedge clk);
        b_util = 1'b1;
        repeat (2) @(negedge clk);
        b_request = 3'b000;
        @(negedge clk);
        b_util = 1'b0;
        @(negedge clk);
        b_request = 3'b011;
        @(negedge clk);
        chk("mid_ptr_m1", b_grant, 3'b010);
        b_util = 1'b1;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_async_gnt",  b_grant, 0);
        chk("mid_async_busy", arb_busy, 0);
        chk("mid_async_cur",  cur_master, 0);
        @(negedge clk);
        rstn   = 1'b1;
        b_util = 1'b0;
        @(negedge clk);
        chk("mid_ptr_reset", b_grant, 3'b001);

`ifdef ARB_TENURE_LIMIT_EN
        // ---------------- tenure limit ----------------
        do_reset();
        b_request = 3'b011;
        @(negedge clk);
        chk("ten_gnt0", b_grant, 3'b001);
        b_util = 1'b1;
        repeat (16) @(negedge clk);
        chk("ten_hold", b_grant, 3'b001);
        @(negedge clk);
        chk("ten_cut", b_grant, 0);
        chk("ten_cut_busy", arb_busy, 1);
        b_util = 1'b0;
        repeat (2) @(negedge clk);
        chk("ten_gnt1", b_grant, 3'b010);

        do_reset();
        b_request = 3'b001;
        @(negedge clk);
        b_util = 1'b1;
        repeat (25) @(negedge clk);
        chk("ten_alone_keep", b_grant, 3'b001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
